// File: rtl/RS5_pkg.sv
// Shared definitions for the console UART transmitter: register map,
// STATUS bit positions, FSM state type and divisor helper.
package RS5_pkg;

  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_DIVISOR = 4'h8;
  localparam logic [3:0] UART_CTRL    = 4'hC;

  localparam int unsigned UART_ST_FULL  = 0;
  localparam int unsigned UART_ST_EMPTY = 1;
  localparam int unsigned UART_ST_BUSY  = 2;
  localparam int unsigned UART_ST_OVF   = 3;
  localparam int unsigned UART_ST_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

  // A programmed divisor of zero behaves as one cycle per bit.
  function automatic logic [15:0] uart_eff_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/console_uart_tx_if.sv
// Peripheral-side data bus: enable-qualified access, byte write enables,
// read data returned registered one cycle after the access.
interface console_uart_tx_if;

  logic        en_i;
  logic [3:0]  we_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output en_i,
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  en_i,
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );

endinterface

// File: rtl/console_uart_tx_fifo.sv
// Byte FIFO for the console transmitter. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module console_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Flags, accepted push/pop and next pointer values.
  always_comb begin
    full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty_o = (wptr_q == rptr_q);
    count_o = wptr_q - rptr_q;
    rdata_o = mem_q[rptr_q[AW-1:0]];
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/console_uart_tx.sv
// Memory-mapped console transmitter: register file, TX FIFO and an 8N1
// serialiser driven by a programmable bit-period down-counter.
module console_uart_tx
  import RS5_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic                     clk,
  input  logic                     sys_reset_i,
  console_uart_tx_if.slave         bus,
  output logic                     tx_o,
  output logic                     irq_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic           wr_acc, rd_acc;
  logic           fifo_push, fifo_pop;
  logic [7:0]     fifo_rdata;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           busy;
  logic [31:0]    status;

  logic [15:0]    div_q, div_d;
  logic           irq_en_q, irq_en_d;
  logic           ovf_q, ovf_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           irq_q, irq_d;

  uart_tx_state_e state_q, state_d;
  logic [15:0]    baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [15:0]    div_lat_q, div_lat_d;
  logic           tx_q, tx_d;
  logic           start_frame;

  console_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_i   (sys_reset_i),
    .push_i  (fifo_push),
    .wdata_i (bus.data_i[7:0]),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Register file: decode writes, sticky overflow, read mux and irq level.
  always_comb begin
    wr_acc    = bus.en_i && (bus.we_i != 4'b0000);
    rd_acc    = bus.en_i && (bus.we_i == 4'b0000);
    fifo_push = wr_acc && (bus.addr_i == UART_TXDATA) && bus.we_i[0];
    busy      = (state_q != IDLE);

    status                       = '0;
    status[UART_ST_FULL]         = fifo_full;
    status[UART_ST_EMPTY]        = fifo_empty;
    status[UART_ST_BUSY]         = busy;
    status[UART_ST_OVF]          = ovf_q;
    status[UART_ST_COUNT +: CW]  = fifo_count;

    div_d    = div_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;

    // A push into a full FIFO is lost even if the serialiser pops this cycle.
    if (fifo_push && fifo_full) begin
      ovf_d = 1'b1;
    end else if (wr_acc && (bus.addr_i == UART_STATUS) && bus.we_i[0] && bus.data_i[UART_ST_OVF]) begin
      ovf_d = 1'b0;
    end

    if (wr_acc && (bus.addr_i == UART_DIVISOR)) begin
      if (bus.we_i[0]) div_d[7:0]  = bus.data_i[7:0];
      if (bus.we_i[1]) div_d[15:8] = bus.data_i[15:8];
    end

    if (wr_acc && (bus.addr_i == UART_CTRL) && bus.we_i[0]) begin
      irq_en_d = bus.data_i[0];
    end

    if (rd_acc) begin
      case (bus.addr_i)
        UART_STATUS:  rdata_d = status;
        UART_DIVISOR: rdata_d = {16'h0000, div_q};
        UART_CTRL:    rdata_d = {31'h0000_0000, irq_en_q};
        default:      rdata_d = '0;
      endcase
    end

    irq_d = irq_en_q && fifo_empty && !busy;
  end

  // Serialiser next-state: every state or data bit lasts div_lat cycles.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    div_lat_d   = div_lat_q;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (baud_q == 16'd0) begin
          state_d = DATA;
          baud_d  = div_lat_q - 16'd1;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = div_lat_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == 16'd0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_d     = IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start is shared by IDLE and the end of STOP so consecutive
    // frames chain with no idle gap; the divisor is captured here only.
    if (start_frame) begin
      fifo_pop  = 1'b1;
      state_d   = START;
      div_lat_d = uart_eff_div(div_q);
      baud_d    = uart_eff_div(div_q) - 16'd1;
      shift_d   = fifo_rdata;
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and register flops.
  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      div_q     <= DEFAULT_DIV;
      irq_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      div_lat_q <= DEFAULT_DIV;
      tx_q      <= 1'b1;
    end else begin
      div_q     <= div_d;
      irq_en_q  <= irq_en_d;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.data_o = rdata_q;
  assign tx_o       = tx_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: bus tasks, a per-cycle tx_o log and a
// frame-level waveform model built from bytes and bit periods.
module tb_console_uart_tx;
  import RS5_pkg::*;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DEF_DIV = 868;
  localparam int          LOGN    = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic txlog [LOGN];
  bit   exp_wave [$];

  console_uart_tx_if bus_if ();

  console_uart_tx #(
    .DEPTH       (DEPTH),
    .DEFAULT_DIV (16'(DEF_DIV))
  ) dut (
    .clk         (clk),
    .sys_reset_i (rst),
    .bus         (bus_if.slave),
    .tx_o        (tx),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cyc < LOGN) txlog[cyc] = tx;

  // Expected line activity of one 8N1 frame: start, 8 data LSB first, stop.
  task automatic model_frame(input logic [7:0] b, input int unsigned div);
    int unsigned d;
    d = (div == 0) ? 1 : div;
    repeat (d) exp_wave.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (d) exp_wave.push_back(b[k]);
    repeat (d) exp_wave.push_back(1'b1);
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] we);
    bus_if.en_i   = 1'b1;
    bus_if.we_i   = we;
    bus_if.addr_i = addr;
    bus_if.data_i = data;
    @(negedge clk);
    bus_if.en_i   = 1'b0;
    bus_if.we_i   = 4'h0;
    bus_if.data_i = '0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    bus_if.en_i   = 1'b1;
    bus_if.we_i   = 4'h0;
    bus_if.addr_i = addr;
    @(negedge clk);
    bus_if.en_i   = 1'b0;
    data = bus_if.data_o;
  endtask

  task automatic wait_wave(input int base);
    int guard;
    guard = 0;
    while (cyc <= base + exp_wave.size() && guard < LOGN) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0 || bus_if.data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%b irq=%b data_o=%h expected tx=1 irq=0 data_o=00000000", tx, irq, bus_if.data_o);
    end
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", rd); end
    bus_read(UART_DIVISOR, rd);
    checks++;
    if (rd !== 32'(DEF_DIV)) begin errors++; $display("FAIL reset_divisor: got %h expected %h", rd, 32'(DEF_DIV)); end
    bus_read(UART_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", rd); end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    bus_write(UART_DIVISOR, 32'hFFFF_1234, 4'hF);
    bus_read(UART_DIVISOR, rd);
    checks++;
    if (rd !== 32'h1234) begin errors++; $display("FAIL divisor_rw: got %h expected 00001234", rd); end
    bus_write(UART_DIVISOR, 32'h0000_ABCD, 4'h2);
    bus_write(4'h6, 32'hFFFF_FFFF, 4'hF);
    bus_write(4'h9, 32'h0000_0000, 4'hF);
    bus_read(UART_DIVISOR, rd);
    checks++;
    if (rd !== 32'hAB34) begin errors++; $display("FAIL divisor_byte_en: got %h expected 0000ab34", rd); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus_if.data_o !== 32'hAB34) begin errors++; $display("FAIL data_o_hold: got %h expected 0000ab34", bus_if.data_o); end
    bus_read(4'h2, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 00000000", rd); end
    bus_read(UART_TXDATA, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 00000000", rd); end
    bus_write(UART_STATUS, 32'hFFFF_FFF7, 4'hF);
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL status_readonly: got %h expected 00000002", rd); end
    bus_write(UART_CTRL, 32'hFFFF_FFFF, 4'hF);
    bus_read(UART_CTRL, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL ctrl_rw: got %h expected 00000001", rd); end
    bus_write(UART_CTRL, 32'h0, 4'h1);
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    int base, bad, first;
    bus_write(UART_DIVISOR, 32'd4, 4'h3);
    exp_wave.delete();
    exp_wave.push_back(1'b1);
    model_frame(8'h55, 4);
    repeat (4) exp_wave.push_back(1'b1);
    base = cyc + 1;
    bus_write(UART_TXDATA, 32'h55, 4'h1);
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h10) begin errors++; $display("FAIL single_status_queued: got %h expected 00000010", rd); end
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("FAIL single_status_busy: got %h expected 00000006", rd); end
    repeat (38) @(negedge clk);
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h6) begin errors++; $display("FAIL single_busy_last_cycle: got %h expected 00000006", rd); end
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL single_busy_drop: got %h expected 00000002", rd); end
    wait_wave(base);
    bad = 0; first = -1;
    foreach (exp_wave[i]) if (txlog[base+i] !== exp_wave[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_wave: %0d samples differ, first at offset %0d got %b expected %b", bad, first, txlog[base+first], exp_wave[first]);
    end
  endtask

  task automatic test_back_to_back();
    int base, bad, first;
    bus_write(UART_DIVISOR, 32'd3, 4'h3);
    exp_wave.delete();
    exp_wave.push_back(1'b1);
    model_frame(8'hF0, 3);
    model_frame(8'h0F, 3);
    repeat (4) exp_wave.push_back(1'b1);
    base = cyc + 1;
    bus_write(UART_TXDATA, 32'hF0, 4'h1);
    bus_write(UART_TXDATA, 32'h0F, 4'h1);
    wait_wave(base);
    bad = 0; first = -1;
    foreach (exp_wave[i]) if (txlog[base+i] !== exp_wave[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_wave: %0d samples differ, first at offset %0d got %b expected %b", bad, first, txlog[base+first], exp_wave[first]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [7:0] b;
    int base, bad, first, n;
    int unsigned div;
    for (int it = 0; it < 4; it++) begin
      div = (it == 0) ? 0 : $urandom_range(1, 5);
      n   = $urandom_range(1, 5);
      bus_write(UART_DIVISOR, 32'(div), 4'h3);
      exp_wave.delete();
      exp_wave.push_back(1'b1);
      base = cyc + 1;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        model_frame(b, div);
        bus_write(UART_TXDATA, {24'h0, b}, 4'h1);
      end
      repeat (4) exp_wave.push_back(1'b1);
      wait_wave(base);
      bad = 0; first = -1;
      foreach (exp_wave[i]) if (txlog[base+i] !== exp_wave[i]) begin bad++; if (first < 0) first = i; end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random_wave[%0d] div=%0d n=%0d: %0d samples differ, first at offset %0d got %b expected %b",
                 it, div, n, bad, first, txlog[base+first], exp_wave[first]);
      end
    end
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL random_status_idle: got %h expected 00000002", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [7:0] burst [17];
    int base, bad, first;
    bus_write(UART_DIVISOR, 32'd2, 4'h3);
    foreach (burst[i]) burst[i] = 8'($urandom);
    exp_wave.delete();
    exp_wave.push_back(1'b1);
    model_frame(8'hC3, 2);
    for (int k = 0; k < DEPTH; k++) model_frame(burst[k], 2);
    repeat (4) exp_wave.push_back(1'b1);
    base = cyc + 1;
    bus_write(UART_TXDATA, 32'hC3, 4'h1);
    for (int k = 0; k < 17; k++) bus_write(UART_TXDATA, {24'h0, burst[k]}, 4'h1);
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h10D) begin errors++; $display("FAIL ovf_status_full: got %h expected 0000010d", rd); end
    bus_write(UART_STATUS, 32'h8, 4'h1);
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h105) begin errors++; $display("FAIL ovf_clear: got %h expected 00000105", rd); end
    wait_wave(base);
    bad = 0; first = -1;
    foreach (exp_wave[i]) if (txlog[base+i] !== exp_wave[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf_wave: %0d samples differ, first at offset %0d got %b expected %b", bad, first, txlog[base+first], exp_wave[first]);
    end
  endtask

  task automatic test_div_change();
    int base, bad, first;
    bus_write(UART_DIVISOR, 32'd4, 4'h3);
    exp_wave.delete();
    exp_wave.push_back(1'b1);
    model_frame(8'hA5, 4);
    model_frame(8'h3C, 8);
    repeat (4) exp_wave.push_back(1'b1);
    base = cyc + 1;
    bus_write(UART_TXDATA, 32'hA5, 4'h1);
    bus_write(UART_TXDATA, 32'h3C, 4'h1);
    repeat (16) @(negedge clk);
    bus_write(UART_DIVISOR, 32'd8, 4'h3);
    wait_wave(base);
    bad = 0; first = -1;
    foreach (exp_wave[i]) if (txlog[base+i] !== exp_wave[i]) begin bad++; if (first < 0) first = i; end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL divchg_wave: %0d samples differ, first at offset %0d got %b expected %b", bad, first, txlog[base+first], exp_wave[first]);
    end
  endtask

  task automatic test_reset_midframe_irq();
    logic [31:0] rd;
    int bad;
    bus_write(UART_DIVISOR, 32'd4, 4'h3);
    bus_write(UART_TXDATA, 32'h81, 4'h1);
    bus_write(UART_TXDATA, 32'h42, 4'h1);
    bus_write(UART_TXDATA, 32'h24, 4'h1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0 || bus_if.data_o !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got tx=%b irq=%b data_o=%h expected tx=1 irq=0 data_o=00000000", tx, irq, bus_if.data_o);
    end
    bus_read(UART_STATUS, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL midreset_status: got %h expected 00000002", rd); end
    bus_read(UART_DIVISOR, rd);
    checks++;
    if (rd !== 32'(DEF_DIV)) begin errors++; $display("FAIL midreset_divisor: got %h expected %h", rd, 32'(DEF_DIV)); end
    bad = 0;
    repeat (30) begin @(negedge clk); if (tx !== 1'b1) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midreset_idle_line: got %0d low samples expected 0", bad); end

    bus_write(UART_DIVISOR, 32'd2, 4'h3);
    bus_write(UART_CTRL, 32'h1, 4'h1);
    bus_write(UART_TXDATA, 32'h99, 4'h1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_during_frame: got %b expected 0", irq); end
    repeat (25) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_frame: got %b expected 1", irq); end
    bus_write(UART_TXDATA, 32'h66, 4'h1);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_on_write: got %b expected 0", irq); end
    repeat (25) @(negedge clk);
  endtask

  initial begin
    bus_if.en_i   = 1'b0;
    bus_if.we_i   = 4'h0;
    bus_if.addr_i = 4'h0;
    bus_if.data_i = '0;
    @(negedge clk);
    test_reset();
    test_regs();
    test_single_frame();
    test_back_to_back();
    test_random();
    test_overflow();
    test_div_change();
    test_reset_midframe_irq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
